// File: rtl/solitaire_pkg.sv
// ---------------------------------------------------------------------------
// solitaire_pkg
// Shared types and helpers for the peg-solitaire design.
//   BOARD_WIDTH  : squares per row/column of the 7x7 bounding box
//   IDLE_COORD   : off-board coordinate used to park the core's request inputs
//   dir_t        : move direction encoding seen by the core
//   ctrl_state_t : input-controller state machine states
//   space_exists : true when (x,y) is a real square of the cross-shaped board
// ---------------------------------------------------------------------------
package solitaire_pkg;

    localparam int         BOARD_WIDTH = 7;
    localparam logic [2:0] IDLE_COORD  = 3'd7;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        SEL_PIECE = 2'd0,
        SEL_DIR   = 2'd1,
        ISSUE     = 2'd2,
        CHECK     = 2'd3
    } ctrl_state_t;

    // The board is a plus shape: a square exists when it is inside the 7x7 box
    // and lies in the centre three columns or the centre three rows.
    function automatic logic space_exists(input logic [2:0] x, input logic [2:0] y);
        logic in_box_s;
        logic in_col_s;
        logic in_row_s;
        in_box_s = (x < 3'(BOARD_WIDTH)) && (y < 3'(BOARD_WIDTH));
        in_col_s = (x >= 3'd2) && (x <= 3'd4);
        in_row_s = (y >= 3'd2) && (y <= 3'd4);
        return in_box_s && (in_col_s || in_row_s);
    endfunction

endpackage

// File: rtl/solitaire_input_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// solitaire_debounce
// One push-button channel: 2-flop synchroniser, counter-based debounce and a
// registered rising-edge detector.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   btn   : raw, asynchronous, bouncing button
//   press : one-cycle pulse when the debounced level rises
// The debounced level only flips after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// ---------------------------------------------------------------------------
module solitaire_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchroniser, debounce counter/level and edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_q_r <= 1'b0;
            cnt_r     <= '0;
            press_r   <= 1'b0;
        end else begin
            sync1_r   <= btn;
            sync2_r   <= sync1_r;
            level_q_r <= level_r;
            press_r   <= level_r & ~level_q_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/solitaire_input_ctrl.sv
// ---------------------------------------------------------------------------
// solitaire_input_ctrl
// Player-input front end for the peg-solitaire core.
//   clk, rst                       : clock, asynchronous active-high reset
//   btn_up/down/left/right/select  : raw push-buttons
//   piece_count_in, game_over_in   : status from the core
//   piece_x, piece_y, direction    : move request to the core (7/7 = idle)
//   cursor_x, cursor_y             : cursor position for display
//   dir_mode                       : high while awaiting a direction
//   move_illegal                   : last issued move was rejected
// A move is presented for exactly one cycle (ISSUE); the following cycle
// (CHECK) compares the core's piece count against the pre-move snapshot.
// ---------------------------------------------------------------------------
module solitaire_input_ctrl
    import solitaire_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_select,
    input  logic [5:0] piece_count_in,
    input  logic       game_over_in,
    output logic [2:0] piece_x,
    output logic [2:0] piece_y,
    output logic [1:0] direction,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       dir_mode,
    output logic       move_illegal
);

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_SELECT = 4;

    logic [4:0]  btn_raw_s;
    logic [4:0]  press_s;

    ctrl_state_t state_r;
    logic [2:0]  cursor_x_r;
    logic [2:0]  cursor_y_r;
    logic [2:0]  piece_x_r;
    logic [2:0]  piece_y_r;
    dir_t        direction_r;
    logic        dir_mode_r;
    logic        move_illegal_r;
    logic [5:0]  snapshot_r;

    logic        consume_s;
    logic        sel_s;
    dir_t        dir_s;
    logic [2:0]  tgt_x_s;
    logic [2:0]  tgt_y_s;
    logic        step_ok_s;

    assign btn_raw_s = {btn_select, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        solitaire_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw_s[i]),
            .press(press_s[i])
        );
    end

    // Press arbitration (select > up > down > left > right) and cursor step target.
    always_comb begin
        consume_s = 1'b0;
        sel_s     = 1'b0;
        dir_s     = LEFT;
        tgt_x_s   = cursor_x_r;
        tgt_y_s   = cursor_y_r;
        step_ok_s = 1'b0;

        if (press_s[BTN_SELECT]) begin
            sel_s = 1'b1;
        end else if (press_s[BTN_UP]) begin
            dir_s = UP;
        end else if (press_s[BTN_DOWN]) begin
            dir_s = DOWN;
        end else if (press_s[BTN_LEFT]) begin
            dir_s = LEFT;
        end else if (press_s[BTN_RIGHT]) begin
            dir_s = RIGHT;
        end else begin
            dir_s = LEFT;
        end

        // Presses are only taken while the player is choosing; ISSUE/CHECK drop them.
        if (!game_over_in && ((state_r == SEL_PIECE) || (state_r == SEL_DIR))) begin
            consume_s = |press_s;
        end else begin
            consume_s = 1'b0;
        end

        // Stepping past 0 or 6 wraps to 7, which space_exists rejects.
        case (dir_s)
            LEFT:    tgt_x_s = cursor_x_r - 3'd1;
            RIGHT:   tgt_x_s = cursor_x_r + 3'd1;
            UP:      tgt_y_s = cursor_y_r - 3'd1;
            DOWN:    tgt_y_s = cursor_y_r + 3'd1;
            default: tgt_x_s = cursor_x_r;
        endcase
        step_ok_s = space_exists(tgt_x_s, tgt_y_s);
    end

    // Controller state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= SEL_PIECE;
            cursor_x_r     <= 3'd3;
            cursor_y_r     <= 3'd3;
            piece_x_r      <= IDLE_COORD;
            piece_y_r      <= IDLE_COORD;
            direction_r    <= LEFT;
            dir_mode_r     <= 1'b0;
            move_illegal_r <= 1'b0;
            snapshot_r     <= 6'd0;
        end else begin
            case (state_r)
                SEL_PIECE: begin
                    if (consume_s) begin
                        move_illegal_r <= 1'b0;
                        if (sel_s) begin
                            state_r    <= SEL_DIR;
                            dir_mode_r <= 1'b1;
                        end else if (step_ok_s) begin
                            cursor_x_r <= tgt_x_s;
                            cursor_y_r <= tgt_y_s;
                        end
                    end
                end
                SEL_DIR: begin
                    if (game_over_in) begin
                        state_r    <= SEL_PIECE;
                        dir_mode_r <= 1'b0;
                    end else if (consume_s) begin
                        move_illegal_r <= 1'b0;
                        if (sel_s) begin
                            state_r    <= SEL_PIECE;
                            dir_mode_r <= 1'b0;
                        end else begin
                            state_r     <= ISSUE;
                            snapshot_r  <= piece_count_in;
                            piece_x_r   <= cursor_x_r;
                            piece_y_r   <= cursor_y_r;
                            direction_r <= dir_s;
                        end
                    end
                end
                ISSUE: begin
                    // The core acts on this closing edge; park the request so it is never repeated.
                    state_r     <= CHECK;
                    piece_x_r   <= IDLE_COORD;
                    piece_y_r   <= IDLE_COORD;
                    direction_r <= LEFT;
                end
                CHECK: begin
                    // An unchanged piece count means the core refused the move.
                    move_illegal_r <= (piece_count_in == snapshot_r);
                    state_r        <= SEL_PIECE;
                    dir_mode_r     <= 1'b0;
                end
                default: begin
                    state_r     <= SEL_PIECE;
                    piece_x_r   <= IDLE_COORD;
                    piece_y_r   <= IDLE_COORD;
                    direction_r <= LEFT;
                    dir_mode_r  <= 1'b0;
                end
            endcase
        end
    end

    assign piece_x      = piece_x_r;
    assign piece_y      = piece_y_r;
    assign direction    = direction_r;
    assign cursor_x     = cursor_x_r;
    assign cursor_y     = cursor_y_r;
    assign dir_mode     = dir_mode_r;
    assign move_illegal = move_illegal_r;

endmodule
